vga_text_render: RTL and testbench
==================================

VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 clk  in  1  pixel clock, 25 MHz; all state on rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 row  in  9  scanner pixel row, 0-479 meaningful while active_in=1.
REQ-004 col  in  10  scanner pixel column, 0-639 meaningful while active_in=1.
REQ-005 active_in  in  1  scanner display-active flag.
REQ-006 hsync_in, vsync_in  in  1 each  scanner sync outputs.
REQ-007 vram_addr  out  13  character RAM address, {row[8:3], col[9:3]}; combinational from row/col.
REQ-008 vram_data  in  16  character cell, valid one cycle after address: [7:0] code, [11:8] fg index, [15:12] bg index.
REQ-009 font_addr  out  11  font ROM address, {code, row[2:0] delayed 1}; combinational.
REQ-010 font_data  in  8  glyph line, valid one cycle after font_addr; bit 7 = leftmost pixel.
REQ-011 cursor_x  in  7 / cursor_y  in  6  cursor cell column/row.
REQ-012 r, g, b  out  4 each  pixel colour, registered.
REQ-013 hsync, vsync, active  out  1 each  delayed syncs/active, registered.

Function
REQ-014 Three-stage pipeline: S1 at edge n captures row[2:0], col[2:0], active_in, hsync_in, vsync_in; S2 at edge n+1 captures vram_data colours/code and S1 fields; S3 at edge n+2 drives outputs.
REQ-015 hsync, vsync, active and rgb shall all reflect the same input sample, exactly 3 clock edges after it; no relative skew.
REQ-016 Pixel bit = font_data[7 - col[2:0]] using col[2:0] delayed 2 stages.
REQ-017 Pixel bit 1 -> palette(fg), 0 -> palette(bg).
REQ-018 Palette index i: I=i[3]; component R/G/B from i[2]/i[1]/i[0]; component = bit ? (I ? 4'hF : 4'hA) : (I ? 4'h5 : 4'h0).
REQ-019 Delayed active=0 -> r=g=b=0 regardless of pixel data.
REQ-020 vram_addr and font_addr outside active region are don't-care but shall remain driven (no X from internal state after reset).
REQ-021 Cell grid 80x60 of 8x8 pixels; RAM stride 128 cells per row, columns 80-127 never displayed.
REQ-022 Upstream wrap (col 639->blank, row 479->blank) requires no special handling; pipeline runs freely every cycle, no stall.

Reset
REQ-023 rstn=0 shall asynchronously clear all pipeline registers: r=g=b=0, hsync=0, vsync=0, active=0, frame counter=0.
REQ-024 Reset asserted mid-frame shall flush pipeline; first valid output appears 3 edges after first post-reset input sample.

Configuration
REQ-025 Macro CURSOR_EN defined: 5-bit frame counter increments on each delayed vsync rising edge (wraps 31->0); when counter[4]=1 and cell = (cursor_y, cursor_x) and pixel row[2:0]=7, pixel bit forced to 1 (fg underline).
REQ-026 CURSOR_EN undefined: counter and cursor logic absent; cursor_x/cursor_y ports present but ignored; output identical to REQ-016/017.

Verification
REQ-027 Reset: hold rstn=0 with active_in=1, hsync_in=1 -> all outputs 0; release -> outputs follow inputs after 3 edges.
REQ-028 Latency: pulse hsync_in 1->0 at edge k -> hsync 1->0 at edge k+3, same cycle active/rgb change for aligned sample.
REQ-029 Glyph: cell (0,0) vram_data=16'h1F41, font line 0 = 8'b1000_0001 -> pixel row 0: cols 0 and 7 = 12'hFFF, cols 1-6 = 12'h00A.
REQ-030 Addressing: row=17, col=100 -> vram_addr={6'd2,7'd12}; vram_data code 8'h5A -> font_addr={8'h5A,3'd1}.
REQ-031 Blanking: active_in=0 with font_data=8'hFF, fg=15 -> r=g=b=0 three edges later.
REQ-032 CURSOR_EN: cursor (3,2), font_data=0, fg=4 -> during frames 16-31 pixel row 23, cols 24-31 = 12'hA00; frames 0-15 show bg only.

Source files
------------

// File: rtl/vga_text_render.sv
// vga_text_render: 80x60 text-mode pixel pipeline for a 640x480 scanner.
// The scanner position addresses the character RAM combinationally, the
// returned cell addresses the font ROM, and the selected glyph bit is
// coloured through a 16-entry IRGB palette. Syncs and the active flag are
// delayed with the pixel so that all outputs stay aligned, 3 edges after
// the input sample.
//
// Optional feature: define CURSOR_EN to add a 5-bit frame counter (one
// count per delayed vsync rising edge) and a blinking underline cursor on
// pixel row 7 of the cell at (cursor_y, cursor_x). Without CURSOR_EN the
// cursor ports are accepted but have no effect.
//
// Handshake: none. The pipeline advances on every clock with no stall;
// vram_data and font_data are expected one clock after their addresses.
module vga_text_render (
  input  logic        clk,
  input  logic        rstn,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [12:0] vram_addr,
  input  logic [15:0] vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_x,
  input  logic [5:0]  cursor_y,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        active
);

  // IRGB palette: bit 3 is intensity, bits 2..0 select R, G, B.
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [3:0] on_lvl;
    logic [3:0] off_lvl;
    on_lvl  = idx[3] ? 4'hF : 4'hA;
    off_lvl = idx[3] ? 4'h5 : 4'h0;
    palette = {idx[2] ? on_lvl : off_lvl,
               idx[1] ? on_lvl : off_lvl,
               idx[0] ? on_lvl : off_lvl};
  endfunction

  // Stage 1 registers: sub-cell position and scanner flags.
  logic [2:0] s1_line;
  logic [2:0] s1_px;
  logic       s1_active;
  logic       s1_hsync;
  logic       s1_vsync;

  // Stage 2 registers: cell colours plus the stage 1 fields.
  logic [2:0] s2_px;
  logic [3:0] s2_fg;
  logic [3:0] s2_bg;
  logic       s2_active;
  logic       s2_hsync;
  logic       s2_vsync;

  logic       pix_bit;
  logic [11:0] pix_rgb;

  // Character RAM address: 128-cell stride, columns 80-127 never shown.
  assign vram_addr = {row[8:3], col[9:3]};

  // Font ROM address: code from the RAM read plus the glyph line that
  // travelled alongside it through stage 1.
  assign font_addr = {vram_data[7:0], s1_line};

`ifdef CURSOR_EN
  logic [6:0] s1_cell_x;
  logic [5:0] s1_cell_y;
  logic       s2_cursor_hit;
  logic [4:0] frame_cnt;
  logic       vsync_prev;

  // Stage 1 cursor fields: which cell the sample belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_cell_x <= '0;
      s1_cell_y <= '0;
    end else begin
      s1_cell_x <= col[9:3];
      s1_cell_y <= row[8:3];
    end
  end

  // Stage 2 cursor flag: sample lies on the underline row of the cursor cell.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_cursor_hit <= 1'b0;
    end else begin
      s2_cursor_hit <= (s1_cell_x == cursor_x) && (s1_cell_y == cursor_y) &&
                       (s1_line == 3'd7);
    end
  end

  // Frame counter: counts rising edges of the delayed vsync; bit 4 blinks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt  <= '0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      if (vsync && !vsync_prev) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  // Glyph bit, forced on for the visible half of the cursor blink.
  always_comb begin
    pix_bit = font_data[3'd7 - s2_px];
    if (s2_cursor_hit && frame_cnt[4]) begin
      pix_bit = 1'b1;
    end
  end
`else
  // Cursor ports are intentionally ignored in this build.
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x, cursor_y};

  // Glyph bit: bit 7 of the font line is the leftmost pixel.
  always_comb begin
    pix_bit = font_data[3'd7 - s2_px];
  end
`endif

  // Colour lookup; blanked outside the active region.
  always_comb begin
    pix_rgb = 12'h000;
    if (s2_active) begin
      pix_rgb = palette(pix_bit ? s2_fg : s2_bg);
    end
  end

  // Stage 1: capture the scanner sample that the RAM read belongs to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_line   <= '0;
      s1_px     <= '0;
      s1_active <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
    end else begin
      s1_line   <= row[2:0];
      s1_px     <= col[2:0];
      s1_active <= active_in;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
    end
  end

  // Stage 2: capture cell colours while the font ROM read is in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_px     <= '0;
      s2_fg     <= '0;
      s2_bg     <= '0;
      s2_active <= 1'b0;
      s2_hsync  <= 1'b0;
      s2_vsync  <= 1'b0;
    end else begin
      s2_px     <= s1_px;
      s2_fg     <= vram_data[11:8];
      s2_bg     <= vram_data[15:12];
      s2_active <= s1_active;
      s2_hsync  <= s1_hsync;
      s2_vsync  <= s1_vsync;
    end
  end

  // Stage 3: registered outputs, all from the same input sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      active <= 1'b0;
    end else begin
      r      <= pix_rgb[11:8];
      g      <= pix_rgb[7:4];
      b      <= pix_rgb[3:0];
      hsync  <= s2_hsync;
      vsync  <= s2_vsync;
      active <= s2_active;
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render: reset, addressing, glyph colouring,
// sync/active alignment, blanking, mid-frame reset and (with CURSOR_EN)
// the blinking underline cursor. Output words are packed as
// {hsync, vsync, active, r, g, b}.
module tb_vga_text_render;

  logic        clk;
  logic        rstn;
  logic [8:0]  row;
  logic [9:0]  col;
  logic        active_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [12:0] vram_addr;
  logic [15:0] vram_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hsync;
  logic        vsync;
  logic        active;

  logic [15:0] vram_mem [0:8191];
  logic [7:0]  font_mem [0:2047];

  logic [14:0] exp_q [$];
  int n_vec;
  int n_err;

  vga_text_render dut (
    .clk(clk), .rstn(rstn), .row(row), .col(col), .active_in(active_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .vram_addr(vram_addr),
    .vram_data(vram_data), .font_addr(font_addr), .font_data(font_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .active(active)
  );

  // Clock and memory models (synchronous reads, one cycle latency).
  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    vram_data <= vram_mem[vram_addr];
    font_data <= font_mem[font_addr];
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  // Driver task: present one scanner sample.
  task automatic drive(input logic [8:0] rw, input logic [9:0] cl,
                       input logic act, input logic hs, input logic vs);
    row       = rw;
    col       = cl;
    active_in = act;
    hsync_in  = hs;
    vsync_in  = vs;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    logic [14:0] exp_tab [4];
    exp_tab = '{15'h0000, 15'h0000, 15'h7000, 15'h7000};
    rstn = 1'b0;
    drive(9'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = {hsync, vsync, active, r, g, b};
      n_vec++;
      if (got !== 15'h0000) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h want 0000", i, got);
      end
    end
    n_vec++;
    if ($isunknown({vram_addr, font_addr})) begin
      n_err++;
      $display("FAIL reset_addr_x: vram_addr %h font_addr %h", vram_addr, font_addr);
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      got = {hsync, vsync, active, r, g, b};
      n_vec++;
      if (got !== exp_tab[i]) begin
        n_err++;
        $display("FAIL reset_release[%0d]: got %h want %h", i, got, exp_tab[i]);
      end
    end
  endtask

  task automatic test_addressing();
    vram_mem[268] = 16'h005A;
    drive(9'd17, 10'd100, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (vram_addr !== 13'd268) begin
      n_err++;
      $display("FAIL addr_17_100: got %0d want 268", vram_addr);
    end
    @(posedge clk); #1;
    n_vec++;
    if (font_addr !== 11'h2D1) begin
      n_err++;
      $display("FAIL font_addr_5a: got %h want 2d1", font_addr);
    end
    drive(9'd479, 10'd639, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (vram_addr !== 13'd7631) begin
      n_err++;
      $display("FAIL addr_479_639: got %0d want 7631", vram_addr);
    end
    drive(9'd8, 10'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (vram_addr !== 13'd129) begin
      n_err++;
      $display("FAIL addr_8_8: got %0d want 129", vram_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_glyph();
    logic [14:0] got;
    logic [14:0] want;
    logic [14:0] exp_tab [16];
    vram_mem[0]     = 16'h1F41;
    vram_mem[1]     = 16'h2C33;
    font_mem[11'h208] = 8'h81;
    font_mem[11'h199] = 8'hF0;
    exp_tab = '{15'h5FFF, 15'h500A, 15'h500A, 15'h500A,
                15'h500A, 15'h500A, 15'h500A, 15'h5FFF,
                15'h5F55, 15'h5F55, 15'h5F55, 15'h5F55,
                15'h50A0, 15'h50A0, 15'h50A0, 15'h50A0};
    exp_q = {};
    for (int i = 0; i < 18; i++) begin
      if (i < 8) begin
        drive(9'd0, 10'(i), 1'b1, 1'b1, 1'b0);
        exp_q.push_back(exp_tab[i]);
      end else if (i < 16) begin
        drive(9'd1, 10'(i), 1'b1, 1'b1, 1'b0);
        exp_q.push_back(exp_tab[i]);
      end else begin
        drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      if (i >= 2) begin
        want = exp_q.pop_front();
        got  = {hsync, vsync, active, r, g, b};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL glyph[%0d]: got %h want %h", i - 2, got, want);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [14:0] got;
    logic [14:0] want;
    logic [2:0]  flags [6];
    logic [9:0]  cols [6];
    logic [14:0] exp_tab [6];
    flags   = '{3'b100, 3'b100, 3'b000, 3'b010, 3'b111, 3'b000};
    cols    = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd1, 10'd0};
    exp_tab = '{15'h4000, 15'h4000, 15'h0000, 15'h2000, 15'h700A, 15'h0000};
    exp_q = {};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        drive(9'd0, cols[i], flags[i][0], flags[i][2], flags[i][1]);
        exp_q.push_back(exp_tab[i]);
      end else begin
        drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      if (i >= 2) begin
        want = exp_q.pop_front();
        got  = {hsync, vsync, active, r, g, b};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL latency[%0d]: got %h want %h", i - 2, got, want);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [14:0] got;
    logic [14:0] want;
    vram_mem[128]     = 16'h0F07;
    font_mem[11'h038] = 8'hFF;
    exp_q = {};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        drive(9'd8, 10'(i), 1'b0, 1'b0, 1'b1);
        exp_q.push_back(15'h2000);
      end else if (i == 4) begin
        drive(9'd8, 10'd4, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(15'h3FFF);
      end else begin
        drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      if (i >= 2) begin
        want = exp_q.pop_front();
        got  = {hsync, vsync, active, r, g, b};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL blanking[%0d]: got %h want %h", i - 2, got, want);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [14:0] got;
    logic [14:0] exp_tab [4];
    exp_tab = '{15'h0000, 15'h0000, 15'h5FFF, 15'h500A};
    for (int i = 0; i < 3; i++) begin
      drive(9'd0, 10'(i), 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    #4;
    rstn = 1'b0;
    #1;
    got = {hsync, vsync, active, r, g, b};
    n_vec++;
    if (got !== 15'h0000) begin
      n_err++;
      $display("FAIL midreset_async: got %h want 0000", got);
    end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(9'd0, 10'(i), 1'b1, 1'b1, 1'b0);
      else       drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      got = {hsync, vsync, active, r, g, b};
      n_vec++;
      if (got !== exp_tab[i]) begin
        n_err++;
        $display("FAIL midreset_resume[%0d]: got %h want %h", i, got, exp_tab[i]);
      end
    end
  endtask

`ifdef CURSOR_EN
  task automatic test_cursor();
    logic [14:0] got;
    logic [14:0] want;
    vram_mem[259] = 16'h0400;
    rstn = 1'b0;
    drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      exp_q = {};
      for (int i = 0; i < 11; i++) begin
        if (i < 8) begin
          drive(9'd23, 10'(24 + i), 1'b1, 1'b0, 1'b0);
          exp_q.push_back(pass == 0 ? 15'h1000 : 15'h1A00);
        end else if (i == 8) begin
          drive(9'd22, 10'd24, 1'b1, 1'b0, 1'b0);
          exp_q.push_back(15'h1000);
        end else begin
          drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        if (i >= 2) begin
          want = exp_q.pop_front();
          got  = {hsync, vsync, active, r, g, b};
          n_vec++;
          if (got !== want) begin
            n_err++;
            $display("FAIL cursor_p%0d[%0d]: got %h want %h", pass, i - 2, got, want);
          end
        end
      end
      if (pass == 0) begin
        for (int f = 0; f < 16; f++) begin
          drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b1);
          @(posedge clk); #1;
          drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
          @(posedge clk); #1;
        end
        repeat (4) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    cursor_x = 7'd3;
    cursor_y = 6'd2;
    for (int i = 0; i < 8192; i++) vram_mem[i] = 16'h0000;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
    rstn = 1'b0;
    drive(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_addressing();
    test_glyph();
    test_latency();
    test_blanking();
    test_reset_midframe();
`ifdef CURSOR_EN
    test_cursor();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
